// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle restoring divider for DIV/REM/DIVU/REMU.
// The FSM walks IDLE -> CALC (32 cycles, one quotient bit each) -> FIXUP
// (sign correction, RESULT registered) -> DONE (one-cycle VALID strobe).
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow jump
// straight from IDLE to DONE with the architected result.
module div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            START,
  input  logic [4:0]      SELECT,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  input  logic            FLUSH,
  output logic            BUSY,
  output logic            STALL,
  output logic            VALID,
  output logic [XLEN-1:0] RESULT
);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t          state;
  logic [5:0]      count;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] divisor;
  logic [XLEN-1:0] dividend_raw;
  logic            q_neg;
  logic            r_neg;
  logic            op_rem;
  logic            div_zero;

  logic            legal_sel;
  logic            is_signed;
  logic            accept;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            in_zero;
  logic [XLEN:0]   shifted;
  logic            fits;
  logic [XLEN-1:0] diff;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
`ifdef DIV_EARLY_OUT_EN
  logic            in_ovf;
  logic [XLEN-1:0] early_res;
`endif

  // Request decode, operand magnitudes and one restoring-division step
  always_comb begin
    legal_sel = (SELECT[4:2] == 3'b011);
    is_signed = ~SELECT[1];
    accept    = (state == IDLE) && START && legal_sel && !FLUSH;
    a_neg     = is_signed & DATA1[XLEN-1];
    b_neg     = is_signed & DATA2[XLEN-1];
    a_mag     = a_neg ? -DATA1 : DATA1;
    b_mag     = b_neg ? -DATA2 : DATA2;
    in_zero   = (DATA2 == '0);
    shifted   = {rem, quo[XLEN-1]};
    fits      = (shifted >= {1'b0, divisor});
    diff      = shifted[XLEN-1:0] - divisor;
    quo_fix   = q_neg ? -quo : quo;
    rem_fix   = r_neg ? -rem : rem;
`ifdef DIV_EARLY_OUT_EN
    in_ovf    = is_signed && (DATA1 == {1'b1, {(XLEN-1){1'b0}}}) && (DATA2 == '1);
    if (in_zero)
      early_res = SELECT[0] ? DATA1 : '1;
    else
      early_res = SELECT[0] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
`endif
  end

  // Status outputs decoded from the state register
  always_comb begin
    BUSY  = (state == CALC) || (state == FIXUP);
    VALID = (state == DONE);
    STALL = BUSY | accept;
  end

  // Sequencer FSM with datapath registers; FLUSH aborts from any state
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state        <= IDLE;
      count        <= '0;
      quo          <= '0;
      rem          <= '0;
      divisor      <= '0;
      dividend_raw <= '0;
      q_neg        <= 1'b0;
      r_neg        <= 1'b0;
      op_rem       <= 1'b0;
      div_zero     <= 1'b0;
      RESULT       <= '0;
    end else if (FLUSH) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            quo          <= a_mag;
            rem          <= '0;
            divisor      <= b_mag;
            dividend_raw <= DATA1;
            q_neg        <= a_neg ^ b_neg;
            r_neg        <= a_neg;
            op_rem       <= SELECT[0];
            div_zero     <= in_zero;
            count        <= '0;
`ifdef DIV_EARLY_OUT_EN
            if (in_zero || in_ovf) begin
              RESULT <= early_res;
              state  <= DONE;
            end else begin
              state  <= CALC;
            end
`else
            state <= CALC;
`endif
          end
        end
        CALC: begin
          quo   <= {quo[XLEN-2:0], fits};
          rem   <= fits ? diff : shifted[XLEN-1:0];
          count <= count + 6'd1;
          if (count == 6'd31)
            state <= FIXUP;
        end
        FIXUP: begin
          if (div_zero)
            RESULT <= op_rem ? dividend_raw : '1;
          else
            RESULT <= op_rem ? rem_fix : quo_fix;
          state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed-vector bench for div_sequencer.
// Expected latencies for zero/overflow cases follow DIV_EARLY_OUT_EN.
module tb_div_sequencer;

  logic        CLK;
  logic        RESET_N;
  logic        START;
  logic [4:0]  SELECT;
  logic [31:0] DATA1;
  logic [31:0] DATA2;
  logic        FLUSH;
  logic        BUSY;
  logic        STALL;
  logic        VALID;
  logic [31:0] RESULT;

  int checks;
  int failures;

  localparam logic [4:0] OP_DIV  = 5'b01100;
  localparam logic [4:0] OP_REM  = 5'b01101;
  localparam logic [4:0] OP_DIVU = 5'b01110;
  localparam logic [4:0] OP_REMU = 5'b01111;
  localparam int FULL_LAT = 34;
`ifdef DIV_EARLY_OUT_EN
  localparam int EO_LAT = 1;
`else
  localparam int EO_LAT = 34;
`endif

  div_sequencer #(.XLEN(32)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .START   (START),
    .SELECT  (SELECT),
    .DATA1   (DATA1),
    .DATA2   (DATA2),
    .FLUSH   (FLUSH),
    .BUSY    (BUSY),
    .STALL   (STALL),
    .VALID   (VALID),
    .RESULT  (RESULT)
  );

  // Free-running clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Count one comparison and report it if it does not match
  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Issue one operation and follow it to its VALID strobe
  task automatic apply_stimulus(input string tag, input logic [4:0] sel, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] exp_res,
                                input int exp_lat, input bit poke_start);
    int lat;
    lat = 0;
    @(negedge CLK);
    START = 1'b1; SELECT = sel; DATA1 = a; DATA2 = b;
    #1 check_output({tag, " stall"}, 32'(STALL), 32'd1);
    @(posedge CLK);
    #1;
    START = 1'b0; DATA1 = $urandom; DATA2 = $urandom;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge CLK);
      START = 1'b0;
      if (k == 1)
        check_output({tag, " busy"}, 32'(BUSY), (exp_lat > 1) ? 32'd1 : 32'd0);
      if (k == 3 && poke_start) begin
        START = 1'b1; SELECT = OP_DIVU; DATA1 = 32'd999; DATA2 = 32'd1;
      end
      if (k == 5)
        DATA2 = $urandom;
      if (VALID)
        lat = k;
    end
    START = 1'b0;
    check_output({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check_output({tag, " result"}, RESULT, exp_res);
    @(negedge CLK);
    check_output({tag, " valid drop"}, 32'(VALID), 32'd0);
    check_output({tag, " hold"}, RESULT, exp_res);
  endtask

  // Watch a window of cycles and return how many VALID strobes appeared
  task automatic count_valid(input int cycles, output int seen);
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge CLK);
      if (VALID) seen++;
    end
  endtask

  // Directed test sequence
  initial begin
    int seen;
    checks = 0; failures = 0;
    RESET_N = 1'b0; START = 1'b0; SELECT = 5'd0; DATA1 = '0; DATA2 = '0; FLUSH = 1'b0;
    #12;
    check_output("reset busy", 32'(BUSY), 32'd0);
    check_output("reset valid", 32'(VALID), 32'd0);
    check_output("reset stall", 32'(STALL), 32'd0);
    check_output("reset result", RESULT, 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;

    apply_stimulus("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd14, FULL_LAT, 0);
    apply_stimulus("remu 100/7", OP_REMU, 32'd100, 32'd7, 32'd2, FULL_LAT, 0);
    apply_stimulus("div -7/2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, FULL_LAT, 0);
    apply_stimulus("rem -7/2", OP_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, FULL_LAT, 0);
    apply_stimulus("div -100/7", OP_DIV, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, FULL_LAT, 0);
    apply_stimulus("rem -100/7", OP_REM, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, FULL_LAT, 0);
    apply_stimulus("div 100/-7", OP_DIV, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, FULL_LAT, 0);
    apply_stimulus("rem 100/-7", OP_REM, 32'd100, 32'hFFFFFFF9, 32'd2, FULL_LAT, 0);
    apply_stimulus("divu max/1", OP_DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, FULL_LAT, 0);
    apply_stimulus("remu max/16", OP_REMU, 32'hFFFFFFFF, 32'd16, 32'd15, FULL_LAT, 0);
    apply_stimulus("div 5/0", OP_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, EO_LAT, 0);
    apply_stimulus("rem 5/0", OP_REM, 32'd5, 32'd0, 32'd5, EO_LAT, 0);
    apply_stimulus("div -5/0", OP_DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, EO_LAT, 0);
    apply_stimulus("rem -5/0", OP_REM, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, EO_LAT, 0);
    apply_stimulus("divu 7/0", OP_DIVU, 32'd7, 32'd0, 32'hFFFFFFFF, EO_LAT, 0);
    apply_stimulus("div ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, EO_LAT, 0);
    apply_stimulus("rem ovf", OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, EO_LAT, 0);

    // Flush mid-CALC: back to IDLE, no strobe, RESULT keeps the last value
    @(negedge CLK);
    START = 1'b1; SELECT = OP_DIVU; DATA1 = 32'd1000; DATA2 = 32'd3;
    @(posedge CLK);
    #1 START = 1'b0;
    for (int k = 1; k <= 10; k++) @(negedge CLK);
    FLUSH = 1'b1;
    @(negedge CLK);
    FLUSH = 1'b0;
    check_output("flush busy", 32'(BUSY), 32'd0);
    check_output("flush valid", 32'(VALID), 32'd0);
    check_output("flush result", RESULT, 32'd0);
    count_valid(40, seen);
    check_output("flush no valid", 32'(seen), 32'd0);

    // FLUSH wins over a simultaneous START
    @(negedge CLK);
    START = 1'b1; FLUSH = 1'b1; SELECT = OP_DIVU; DATA1 = 32'd9; DATA2 = 32'd3;
    #1 check_output("flush+start stall", 32'(STALL), 32'd0);
    @(negedge CLK);
    START = 1'b0; FLUSH = 1'b0;
    check_output("flush+start busy", 32'(BUSY), 32'd0);

    // START while in CALC is ignored; first operation completes untouched
    apply_stimulus("divu poke", OP_DIVU, 32'd500, 32'd9, 32'd55, FULL_LAT, 1);

    // Reset mid-CALC clears outputs at once and leaves no late strobe
    @(negedge CLK);
    START = 1'b1; SELECT = OP_DIVU; DATA1 = 32'd100; DATA2 = 32'd7;
    @(posedge CLK);
    #1 START = 1'b0;
    for (int k = 1; k <= 20; k++) @(negedge CLK);
    RESET_N = 1'b0;
    #1;
    check_output("rst busy", 32'(BUSY), 32'd0);
    check_output("rst valid", 32'(VALID), 32'd0);
    check_output("rst stall", 32'(STALL), 32'd0);
    check_output("rst result", RESULT, 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    count_valid(40, seen);
    check_output("rst no valid", 32'(seen), 32'd0);

    // Illegal SELECT never stalls nor starts
    @(negedge CLK);
    START = 1'b1; SELECT = 5'b00000; DATA1 = 32'd8; DATA2 = 32'd2;
    #1 check_output("illegal stall", 32'(STALL), 32'd0);
    @(negedge CLK);
    START = 1'b0;
    check_output("illegal busy", 32'(BUSY), 32'd0);
    count_valid(40, seen);
    check_output("illegal no valid", 32'(seen), 32'd0);

    apply_stimulus("divu after rst", OP_DIVU, 32'd100, 32'd7, 32'd14, FULL_LAT, 0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  // Global watchdog so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 SHALL have parameter: XLEN, default 32, operand/result width; all widths below are XLEN=32.
REQ-002 SHALL have port: CLK  input  1  rising-edge clock.
REQ-003 SHALL have port: RESET_N  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: START  input  1  request to begin an operation.
REQ-005 SHALL have port: SELECT  input  5  op code: 01100 DIV, 01101 REM, 01110 DIVU, 01111 REMU.
REQ-006 SHALL have port: DATA1  input  32  dividend.
REQ-007 SHALL have port: DATA2  input  32  divisor.
REQ-008 SHALL have port: FLUSH  input  1  abort the in-flight operation.
REQ-009 SHALL have port: BUSY  output  1  operation in progress.
REQ-010 SHALL have port: STALL  output  1  pipeline hold request.
REQ-011 SHALL have port: VALID  output  1  one-cycle result strobe.
REQ-012 SHALL have port: RESULT  output  32  quotient or remainder.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, FIXUP, DONE; no other state is reachable.
REQ-014 SHALL accept START only in IDLE with a legal SELECT and FLUSH low, latching DATA1, DATA2 and SELECT at that edge (cycle t).
REQ-015 SHALL ignore START in any state other than IDLE, and SHALL ignore START with an illegal SELECT (state stays IDLE).
REQ-016 SHALL convert signed operands (DIV, REM) to magnitudes at accept, and SHALL record quotient sign = sign(DATA1) XOR sign(DATA2) and remainder sign = sign(DATA1).
REQ-017 SHALL perform restoring division in CALC, one quotient bit per cycle, using a 6-bit counter over cycles t+1 to t+32 (exactly 32 cycles).
REQ-018 SHALL apply sign correction in FIXUP (cycle t+33) and register RESULT.
REQ-019 SHALL pulse VALID high for exactly one cycle in DONE (cycle t+34) and return to IDLE on the next edge.
REQ-020 SHALL hold RESULT stable from DONE until the next accepted operation completes.
REQ-021 SHALL drive BUSY high in CALC and FIXUP only.
REQ-022 SHALL drive STALL combinationally as BUSY OR (IDLE AND START AND legal SELECT AND NOT FLUSH).
REQ-023 SHALL ignore DATA1 and DATA2 changes while BUSY.
REQ-024 SHALL produce, for divisor 0: DIV/DIVU result 0xFFFFFFFF; REM/REMU result equal to the latched DATA1.
REQ-025 SHALL produce, for DIV/REM with 0x80000000 / 0xFFFFFFFF: DIV result 0x80000000; REM result 0x00000000.
REQ-026 SHALL round the signed quotient toward zero and give the remainder the sign of the dividend.
REQ-027 SHALL, on FLUSH in any state, enter IDLE on the next edge with no VALID pulse; RESULT keeps its prior value; FLUSH has priority over a simultaneous START.

Reset
REQ-028 SHALL, while RESET_N is low, immediately force state IDLE, counter 0, internal registers 0, and BUSY=0, VALID=0, RESULT=0x00000000; STALL=0 unless START qualifies per REQ-022.
REQ-029 SHALL abandon an operation interrupted by reset mid-CALC with no VALID pulse after release; the first START after release SHALL behave per REQ-014.

Configuration
REQ-030 SHALL recognise macro DIV_EARLY_OUT_EN.
REQ-031 SHALL, when DIV_EARLY_OUT_EN is defined, route divide-by-zero and signed-overflow cases from IDLE directly to DONE with the REQ-024/025 result: VALID at t+1, BUSY stays 0, STALL high only in cycle t.
REQ-032 SHALL, when DIV_EARLY_OUT_EN is undefined, take the full 34-cycle path for all cases with identical result values.

Verification
REQ-033 SHALL cover: DIVU 100/7 -> VALID at t+34, RESULT=14; then REMU 100/7 -> RESULT=2.
REQ-034 SHALL cover: DIV -7/2 (0xFFFFFFF9, 2) -> RESULT=0xFFFFFFFD; REM same operands -> RESULT=0xFFFFFFFF.
REQ-035 SHALL cover: DIV 5/0 -> RESULT=0xFFFFFFFF and REM 5/0 -> RESULT=5; VALID at t+1 with DIV_EARLY_OUT_EN defined, t+34 without.
REQ-036 SHALL cover: DIV 0x80000000/0xFFFFFFFF -> RESULT=0x80000000; REM same operands -> RESULT=0.
REQ-037 SHALL cover: FLUSH at t+10 -> IDLE at t+11, no VALID, RESULT unchanged; START with DATA2 changed at t+5 -> result unaffected.
REQ-038 SHALL cover: RESET_N low at t+20 -> outputs 0 immediately; START in CALC -> ignored; START with SELECT=00000 -> STALL=0, stays IDLE.
